// File: rtl/demo_sequencer.sv
// rtl/demo_sequencer.sv - frame timeline sequencer with pause/step/loop/jump; optional DEMO_SEQ_BLANK_EN
module demo_sequencer #(
    parameter int PART_BITS    = 3,
    parameter int FRAME_BITS   = 7,
    parameter int BLANK_FRAMES = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  frame_tick,
    input  logic                  pause,
    input  logic                  step,
    input  logic                  loop_en,
    input  logic                  jump_req,
    input  logic [PART_BITS-1:0]  jump_part,
    output logic                  jump_ack,
    output logic [PART_BITS-1:0]  part,
    output logic [FRAME_BITS-1:0] frame,
    output logic                  part_start,
    output logic                  blank,
    output logic                  beat_1_3,
    output logic [4:0]            envelope,
    output logic                  running
);

    localparam logic [1:0] ST_RUN  = 2'd0;
    localparam logic [1:0] ST_HOLD = 2'd1;
`ifdef DEMO_SEQ_BLANK_EN
    localparam logic [1:0] ST_BLANK = 2'd2;
`endif

    logic [1:0]            state_q, state_d;
    logic [PART_BITS-1:0]  part_q, part_d;
    logic [FRAME_BITS-1:0] frame_q, frame_d;
    logic                  jump_ack_q, jump_ack_d;
    logic                  part_start_q, part_start_d;
    logic                  step_pending_q, step_pending_d;
    logic                  do_adv;
    logic                  adv_wrap;
    logic [PART_BITS-1:0]  adv_part;
`ifdef DEMO_SEQ_BLANK_EN
    logic                  blank_q, blank_d;
    logic [3:0]            blank_cnt_q, blank_cnt_d;
`else
    logic                  unused_blank_cfg;
    assign unused_blank_cfg = |BLANK_FRAMES[3:0];
`endif

    assign adv_wrap = (frame_q == {FRAME_BITS{1'b1}});
    assign adv_part = loop_en ? part_q : part_q + 1'b1;

    always_comb begin
        state_d        = state_q;
        part_d         = part_q;
        frame_d        = frame_q;
        jump_ack_d     = 1'b0;
        part_start_d   = 1'b0;
        step_pending_d = step_pending_q;
        do_adv         = 1'b0;
`ifdef DEMO_SEQ_BLANK_EN
        blank_d        = blank_q;
        blank_cnt_d    = blank_cnt_q;
`endif
        if (!frame_tick) begin
            // Step requests only latch while held; any other state discards them
            if (state_q == ST_HOLD) begin
                if (step) step_pending_d = 1'b1;
            end else begin
                step_pending_d = 1'b0;
            end
        end else if (jump_req) begin
            part_d       = jump_part;
            frame_d      = '0;
            part_start_d = 1'b1;
            jump_ack_d   = 1'b1;
            state_d      = pause ? ST_HOLD : ST_RUN;
`ifdef DEMO_SEQ_BLANK_EN
            blank_d      = 1'b0;
            blank_cnt_d  = '0;
`endif
        end else begin
            case (state_q)
                ST_RUN: begin
                    if (pause) state_d = ST_HOLD;
                    else       do_adv  = 1'b1;
                end
                ST_HOLD: begin
                    if (!pause) begin
                        state_d = ST_RUN;
                        do_adv  = 1'b1;
                    end else if (step_pending_q || step) begin
                        do_adv         = 1'b1;
                        step_pending_d = 1'b0;
                    end
                end
`ifdef DEMO_SEQ_BLANK_EN
                ST_BLANK: begin
                    if (blank_cnt_q == 4'd0) begin
                        state_d = pause ? ST_HOLD : ST_RUN;
                        blank_d = 1'b0;
                    end else begin
                        blank_cnt_d = blank_cnt_q - 4'd1;
                    end
                end
`endif
                default: state_d = ST_RUN;
            endcase
            if (do_adv) begin
                frame_d = frame_q + 1'b1;
                if (adv_wrap) begin
                    part_d       = adv_part;
                    part_start_d = 1'b1;
`ifdef DEMO_SEQ_BLANK_EN
                    if (!loop_en) begin
                        state_d     = ST_BLANK;
                        blank_d     = 1'b1;
                        blank_cnt_d = 4'(BLANK_FRAMES - 1);
                    end
`endif
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q        <= ST_RUN;
            part_q         <= '0;
            frame_q        <= '0;
            jump_ack_q     <= 1'b0;
            part_start_q   <= 1'b0;
            step_pending_q <= 1'b0;
`ifdef DEMO_SEQ_BLANK_EN
            blank_q        <= 1'b0;
            blank_cnt_q    <= '0;
`endif
        end else begin
            state_q        <= state_d;
            part_q         <= part_d;
            frame_q        <= frame_d;
            jump_ack_q     <= jump_ack_d;
            part_start_q   <= part_start_d;
            step_pending_q <= step_pending_d;
`ifdef DEMO_SEQ_BLANK_EN
            blank_q        <= blank_d;
            blank_cnt_q    <= blank_cnt_d;
`endif
        end
    end

    assign part       = part_q;
    assign frame      = frame_q;
    assign jump_ack   = jump_ack_q;
    assign part_start = part_start_q;
`ifdef DEMO_SEQ_BLANK_EN
    assign blank      = blank_q;
`else
    assign blank      = 1'b0;
`endif
    assign beat_1_3   = (frame_q[5:4] == 2'b10);
    assign envelope   = 5'd31 - {frame_q[3:0], 1'b0};
    assign running    = (state_q == ST_RUN);

endmodule

// File: tb/tb_demo_sequencer.sv
// tb/tb_demo_sequencer.sv - directed self-checking bench for demo_sequencer
module tb_demo_sequencer;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       frame_tick = 1'b0;
    logic       pause = 1'b0;
    logic       step = 1'b0;
    logic       loop_en = 1'b0;
    logic       jump_req = 1'b0;
    logic [2:0] jump_part = 3'd0;
    logic       jump_ack;
    logic [2:0] part;
    logic [6:0] frame;
    logic       part_start;
    logic       blank;
    logic       beat_1_3;
    logic [4:0] envelope;
    logic       running;

    int n_cmp = 0;
    int n_bad = 0;

    demo_sequencer #(.PART_BITS(3), .FRAME_BITS(7), .BLANK_FRAMES(2)) dut (
        .clk(clk), .rst_n(rst_n), .frame_tick(frame_tick), .pause(pause),
        .step(step), .loop_en(loop_en), .jump_req(jump_req), .jump_part(jump_part),
        .jump_ack(jump_ack), .part(part), .frame(frame), .part_start(part_start),
        .blank(blank), .beat_1_3(beat_1_3), .envelope(envelope), .running(running)
    );

    always #5 clk = ~clk;

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic tick();
        frame_tick = 1'b1;
        cyc();
        frame_tick = 1'b0;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic do_reset();
        rst_n = 1'b0; pause = 1'b0; step = 1'b0; loop_en = 1'b0; jump_req = 1'b0;
        cyc(); cyc();
        rst_n = 1'b1;
        cyc();
    endtask

    task automatic jump_to(input logic [2:0] p);
        jump_req = 1'b1; jump_part = p;
        tick();
        jump_req = 1'b0;
        cyc();
    endtask

    task automatic test_reset();
        do_reset();
        n_cmp++; if (part !== 3'd0) begin n_bad++; $display("FAIL reset_part got %0d want 0", part); end
        n_cmp++; if (frame !== 7'd0) begin n_bad++; $display("FAIL reset_frame got %0d want 0", frame); end
        n_cmp++; if (jump_ack !== 1'b0 || part_start !== 1'b0 || blank !== 1'b0) begin
            n_bad++; $display("FAIL reset_pulses got ack=%b ps=%b blank=%b want 0", jump_ack, part_start, blank); end
        n_cmp++; if (running !== 1'b1) begin n_bad++; $display("FAIL reset_running got %b want 1", running); end
        n_cmp++; if (envelope !== 5'd31 || beat_1_3 !== 1'b0) begin
            n_bad++; $display("FAIL reset_env got env=%0d beat=%b want 31/0", envelope, beat_1_3); end
    endtask

    task automatic test_sequence();
        int ps_seen;
        ps_seen = 0;
        do_reset();
        for (int i = 1; i <= 127; i++) begin
            tick();
            if (part_start === 1'b1) ps_seen++;
            n_cmp++; if (frame !== 7'(i) || part !== 3'd0) begin
                n_bad++; $display("FAIL seq_frame got p%0d f%0d want p0 f%0d", part, frame, i); end
        end
        tick();
        n_cmp++; if (frame !== 7'd0 || part !== 3'd1) begin
            n_bad++; $display("FAIL seq_wrap got p%0d f%0d want p1 f0", part, frame); end
        n_cmp++; if (part_start !== 1'b1 || ps_seen != 0) begin
            n_bad++; $display("FAIL seq_part_start got %b early=%0d want 1/0", part_start, ps_seen); end
        n_cmp++; if (running !== 1'b1) begin n_bad++; $display("FAIL seq_running got %b want 1", running); end
        cyc();
        n_cmp++; if (part_start !== 1'b0) begin n_bad++; $display("FAIL seq_ps_pulse got %b want 0", part_start); end
`ifdef DEMO_SEQ_BLANK_EN
        ticks(2);
`endif
    endtask

    task automatic test_beat_envelope();
        ticks(32);
        n_cmp++; if (frame !== 7'd32 || beat_1_3 !== 1'b1 || envelope !== 5'd31) begin
            n_bad++; $display("FAIL beat_f32 got f%0d beat=%b env=%0d want 32/1/31", frame, beat_1_3, envelope); end
        ticks(15);
        n_cmp++; if (frame !== 7'd47 || beat_1_3 !== 1'b1 || envelope !== 5'd1) begin
            n_bad++; $display("FAIL beat_f47 got f%0d beat=%b env=%0d want 47/1/1", frame, beat_1_3, envelope); end
        tick();
        n_cmp++; if (frame !== 7'd48 || beat_1_3 !== 1'b0 || envelope !== 5'd31) begin
            n_bad++; $display("FAIL beat_f48 got f%0d beat=%b env=%0d want 48/0/31", frame, beat_1_3, envelope); end
        ticks(5);
        n_cmp++; if (envelope !== 5'd21 || beat_1_3 !== 1'b0) begin
            n_bad++; $display("FAIL beat_f53 got env=%0d beat=%b want 21/0", envelope, beat_1_3); end
    endtask

    task automatic test_wrap_loop();
        do_reset();
        jump_to(3'd7);
        ticks(127);
        n_cmp++; if (part !== 3'd7 || frame !== 7'd127) begin
            n_bad++; $display("FAIL wrap_pre got p%0d f%0d want p7 f127", part, frame); end
        tick();
        n_cmp++; if (part !== 3'd0 || frame !== 7'd0 || part_start !== 1'b1) begin
            n_bad++; $display("FAIL wrap_part got p%0d f%0d ps=%b want p0 f0 1", part, frame, part_start); end
`ifdef DEMO_SEQ_BLANK_EN
        n_cmp++; if (blank !== 1'b1) begin n_bad++; $display("FAIL wrap_blank got %b want 1", blank); end
`else
        n_cmp++; if (blank !== 1'b0) begin n_bad++; $display("FAIL wrap_noblank got %b want 0", blank); end
`endif
        jump_to(3'd7);
        ticks(127);
        loop_en = 1'b1;
        tick();
        n_cmp++; if (part !== 3'd7 || frame !== 7'd0 || part_start !== 1'b1 || blank !== 1'b0) begin
            n_bad++; $display("FAIL loop got p%0d f%0d ps=%b blank=%b want p7 f0 1 0", part, frame, part_start, blank); end
        loop_en = 1'b0;
    endtask

    task automatic test_pause_step();
        do_reset();
        ticks(10);
        pause = 1'b1;
        ticks(5);
        n_cmp++; if (frame !== 7'd10 || running !== 1'b0) begin
            n_bad++; $display("FAIL pause_hold got f%0d run=%b want 10/0", frame, running); end
        step = 1'b1; cyc(); step = 1'b0; cyc();
        tick();
        n_cmp++; if (frame !== 7'd11) begin n_bad++; $display("FAIL step_adv got f%0d want 11", frame); end
        cyc();
        ticks(2);
        n_cmp++; if (frame !== 7'd11) begin n_bad++; $display("FAIL step_once got f%0d want 11", frame); end
        pause = 1'b0;
        tick();
        n_cmp++; if (frame !== 7'd12 || running !== 1'b1) begin
            n_bad++; $display("FAIL unpause got f%0d run=%b want 12/1", frame, running); end
    endtask

    task automatic test_jump();
        do_reset();
        jump_to(3'd2);
        ticks(60);
        jump_req = 1'b1; jump_part = 3'd5;
        tick();
        n_cmp++; if (part !== 3'd5 || frame !== 7'd0 || jump_ack !== 1'b1 || part_start !== 1'b1) begin
            n_bad++; $display("FAIL jump got p%0d f%0d ack=%b ps=%b want p5 f0 1 1", part, frame, jump_ack, part_start); end
        jump_req = 1'b0;
        cyc();
        n_cmp++; if (jump_ack !== 1'b0) begin n_bad++; $display("FAIL jump_ack_pulse got %b want 0", jump_ack); end
        tick();
        n_cmp++; if (part !== 3'd5 || frame !== 7'd1) begin
            n_bad++; $display("FAIL jump_resume got p%0d f%0d want p5 f1", part, frame); end
    endtask

    task automatic test_back_to_back();
        do_reset();
        ticks(3);
        jump_req = 1'b1; jump_part = 3'd4;
        tick();
        tick();
        n_cmp++; if (part !== 3'd4 || frame !== 7'd0 || jump_ack !== 1'b1) begin
            n_bad++; $display("FAIL b2b_jump got p%0d f%0d ack=%b want p4 f0 1", part, frame, jump_ack); end
        jump_req = 1'b0;
        tick(); tick();
        n_cmp++; if (frame !== 7'd2 || jump_ack !== 1'b0) begin
            n_bad++; $display("FAIL b2b_resume got f%0d ack=%b want 2/0", frame, jump_ack); end
    endtask

`ifdef DEMO_SEQ_BLANK_EN
    task automatic test_blank();
        do_reset();
        ticks(128);
        n_cmp++; if (part !== 3'd1 || frame !== 7'd0 || blank !== 1'b1 || running !== 1'b0) begin
            n_bad++; $display("FAIL blank_enter got p%0d f%0d blank=%b run=%b", part, frame, blank, running); end
        tick();
        n_cmp++; if (blank !== 1'b1 || frame !== 7'd0) begin
            n_bad++; $display("FAIL blank_mid got blank=%b f%0d want 1 f0", blank, frame); end
        tick();
        n_cmp++; if (blank !== 1'b0 || frame !== 7'd0 || running !== 1'b1) begin
            n_bad++; $display("FAIL blank_exit got blank=%b f%0d run=%b want 0 f0 1", blank, frame, running); end
        tick();
        n_cmp++; if (frame !== 7'd1) begin n_bad++; $display("FAIL blank_after got f%0d want 1", frame); end
        ticks(127);
        n_cmp++; if (blank !== 1'b1 || part !== 3'd2) begin
            n_bad++; $display("FAIL blank_again got blank=%b p%0d want 1 p2", blank, part); end
        jump_req = 1'b1; jump_part = 3'd3;
        tick();
        jump_req = 1'b0;
        n_cmp++; if (blank !== 1'b0 || part !== 3'd3 || frame !== 7'd0 || jump_ack !== 1'b1) begin
            n_bad++; $display("FAIL blank_jump got blank=%b p%0d f%0d ack=%b", blank, part, frame, jump_ack); end
    endtask
`endif

    initial begin
        test_reset();
        test_sequence();
        test_beat_envelope();
        test_wrap_loop();
        test_pause_step();
        test_jump();
        test_back_to_back();
`ifdef DEMO_SEQ_BLANK_EN
        test_blank();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
